// File: rtl/alarm_bank_if.sv
// Alarm bank signal bundle: controls and time in, edit/ring status out.
interface alarm_bank_if #(
    parameter int unsigned NUM_SLOTS = 4
);
    localparam int unsigned SW = $clog2(NUM_SLOTS);

    logic                 edit_en;
    logic                 push_u;
    logic                 push_d;
    logic                 push_l;
    logic                 push_r;
    logic                 push_c;
    logic                 tick;
    logic [15:0]          cur_time;
    logic                 ack;
    logic [3:0]           sel;
    logic [SW-1:0]        slot;
    logic [15:0]          alarm_val;
    logic [NUM_SLOTS-1:0] armed;
    logic                 ring;
    logic [SW-1:0]        ring_slot;
    logic                 finish;

    // Driver side (user panel / time base)
    modport master (
        output edit_en, push_u, push_d, push_l, push_r, push_c, tick, cur_time, ack,
        input  sel, slot, alarm_val, armed, ring, ring_slot, finish
    );

    // Alarm bank side
    modport slave (
        input  edit_en, push_u, push_d, push_l, push_r, push_c, tick, cur_time, ack,
        output sel, slot, alarm_val, armed, ring, ring_slot, finish
    );
endinterface

// File: rtl/alarm_bank.sv
// Bank of BCD mm:ss alarm slots with a digit editor and a single ring engine.
module alarm_bank #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned RING_SECS = 30
) (
    input  logic        clk,
    input  logic        reset,
    alarm_bank_if.slave bus
);
    localparam int unsigned SW = $clog2(NUM_SLOTS);
    localparam logic [7:0]  RingLimit = 8'(RING_SECS);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StEdit = 1'b1;

    logic [0:0]           state_q, state_d;
    logic                 edit_en_q;
    logic [3:0]           sel_q, sel_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic [15:0]          val_q [NUM_SLOTS];
    logic [15:0]          cur_val;
    logic [15:0]          edit_val;
    logic                 val_we;
    logic [NUM_SLOTS-1:0] armed_q, armed_d;
    logic                 ring_q, ring_d;
    logic [SW-1:0]        ring_slot_q, ring_slot_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 finish_q, finish_d;
    logic                 hit;
    logic [SW-1:0]        hit_idx;

    // Step one BCD digit up or down with wrap; down has priority.
    function automatic logic [3:0] digit_step(input logic [3:0] d, input logic [3:0] max,
                                              input logic up, input logic dn);
        if (dn) return (d == 4'd0) ? max : d - 4'd1;
        if (up) return (d >= max) ? 4'd0 : d + 4'd1;
        return d;
    endfunction

    assign cur_val = val_q[slot_q];

    // Apply up/down to the digit currently pointed at by sel (pre-move position).
    always_comb begin
        edit_val = cur_val;
        for (int k = 0; k < 4; k++) begin
            if (sel_q[k]) begin
                // Tens digits (odd positions) run 0..5, ones digits 0..9.
                edit_val[4*k +: 4] = digit_step(cur_val[4*k +: 4], (k % 2 == 1) ? 4'd5 : 4'd9,
                                                bus.push_u, bus.push_d);
            end
        end
    end

    // Lowest-index armed slot matching the current time, skipping the slot being edited.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (!hit && armed_q[i] && val_q[i] == bus.cur_time &&
                !(state_q == StEdit && slot_q == SW'(i))) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    // Next-state for ring engine and edit FSM; edit actions on armed override ack.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        slot_d      = slot_q;
        armed_d     = armed_q;
        ring_d      = ring_q;
        ring_slot_d = ring_slot_q;
        cnt_d       = cnt_q;
        finish_d    = 1'b0;
        val_we      = 1'b0;

        if (ring_q) begin
            if (bus.ack) begin
                ring_d               = 1'b0;
                armed_d[ring_slot_q] = 1'b0;
            end else if (bus.tick) begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_d == RingLimit) ring_d = 1'b0;
            end
        end else if (bus.tick && hit) begin
            ring_d      = 1'b1;
            ring_slot_d = hit_idx;
            cnt_d       = 8'd0;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.edit_en && !edit_en_q) begin
                    state_d         = StEdit;
                    sel_d           = 4'b1000;
                    armed_d[slot_q] = 1'b0;
                end else if (bus.push_c) begin
                    slot_d = (slot_q == SW'(NUM_SLOTS - 1)) ? '0 : slot_q + 1'b1;
                end
            end
            StEdit: begin
                if (!bus.edit_en) begin
                    state_d         = StIdle;
                    sel_d           = 4'b0000;
                    finish_d        = 1'b1;
                    armed_d[slot_q] = 1'b1;
                end else begin
                    val_we = bus.push_u | bus.push_d;
                    if (bus.push_l)      sel_d = {sel_q[2:0], sel_q[3]};
                    else if (bus.push_r) sel_d = {sel_q[0], sel_q[3:1]};
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            edit_en_q   <= 1'b0;
            sel_q       <= 4'b0000;
            slot_q      <= '0;
            armed_q     <= '0;
            ring_q      <= 1'b0;
            ring_slot_q <= '0;
            cnt_q       <= 8'd0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            edit_en_q   <= bus.edit_en;
            sel_q       <= sel_d;
            slot_q      <= slot_d;
            armed_q     <= armed_d;
            ring_q      <= ring_d;
            ring_slot_q <= ring_slot_d;
            cnt_q       <= cnt_d;
            finish_q    <= finish_d;
        end
    end

    // Alarm value storage, written only by the editor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_SLOTS); i++) val_q[i] <= 16'h0000;
        end else if (val_we) begin
            val_q[slot_q] <= edit_val;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.slot      = slot_q;
    assign bus.alarm_val = cur_val;
    assign bus.armed     = armed_q;
    assign bus.ring      = ring_q;
    assign bus.ring_slot = ring_slot_q;
    assign bus.finish    = finish_q;
endmodule

// File: tb/tb_alarm_bank.sv
// Self-checking bench for alarm_bank: directed scenarios plus random traffic vs a digit-level model.
module tb_alarm_bank;
    localparam int NS = 4;
    localparam int RS = 3;
    localparam logic [6:0] PU = 7'd1, PD = 7'd2, PL = 7'd4, PR = 7'd8;
    localparam logic [6:0] PC = 7'd16, PT = 7'd32, PA = 7'd64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alarm_bank_if #(.NUM_SLOTS(NS)) bus ();
    alarm_bank #(.NUM_SLOTS(NS), .RING_SECS(RS)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per-slot decimal digits, integer digit pointer (3 = leftmost).
    int   m_dig [NS][4];
    bit   m_armed [NS];
    int   m_slot, m_ptr, m_ring_slot, m_cnt;
    bit   m_edit, m_prev, m_ring, m_fin;
    logic        en_r;
    logic [15:0] cur_r;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_val(input int s);
        return m_dig[s][3] * 4096 + m_dig[s][2] * 256 + m_dig[s][1] * 16 + m_dig[s][0];
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_armed[s] = 0;
            for (int k = 0; k < 4; k++) m_dig[s][k] = 0;
        end
        m_slot = 0; m_ptr = 3; m_ring_slot = 0; m_cnt = 0;
        m_edit = 0; m_prev = 0; m_ring = 0; m_fin = 0;
    endtask

    task automatic model_step(input logic [6:0] p, input bit en, input int cur);
        bit na [NS];
        bit found = 0;
        int nslot = m_slot, nptr = m_ptr, nrs = m_ring_slot, ncnt = m_cnt;
        bit nedit = m_edit, nring = m_ring;
        na = m_armed;
        if (m_ring) begin
            if (p[6]) begin
                nring = 0;
                na[m_ring_slot] = 0;
            end else if (p[5]) begin
                ncnt = m_cnt + 1;
                if (ncnt == RS) nring = 0;
            end
        end else if (p[5]) begin
            for (int i = 0; i < NS; i++) begin
                if (!found && m_armed[i] && model_val(i) == cur && !(m_edit && i == m_slot)) begin
                    found = 1; nring = 1; nrs = i; ncnt = 0;
                end
            end
        end
        m_fin = 0;
        if (!m_edit) begin
            if (en && !m_prev) begin
                nedit = 1; nptr = 3; na[m_slot] = 0;
            end else if (p[4]) begin
                nslot = (m_slot + 1) % NS;
            end
        end else if (!en) begin
            nedit = 0; m_fin = 1; na[m_slot] = 1;
        end else begin
            int mx;
            mx = (m_ptr % 2 == 1) ? 5 : 9;
            if (p[1])      m_dig[m_slot][m_ptr] = (m_dig[m_slot][m_ptr] + mx) % (mx + 1);
            else if (p[0]) m_dig[m_slot][m_ptr] = (m_dig[m_slot][m_ptr] + 1) % (mx + 1);
            if (p[2])      nptr = (m_ptr + 1) % 4;
            else if (p[3]) nptr = (m_ptr + 3) % 4;
        end
        m_armed = na; m_slot = nslot; m_ptr = nptr; m_ring_slot = nrs; m_cnt = ncnt;
        m_edit = nedit; m_ring = nring; m_prev = en;
    endtask

    task automatic compare_all();
        int av = 0;
        for (int i = 0; i < NS; i++) if (m_armed[i]) av += (1 << i);
        check_eq("sel", 32'(bus.sel), m_edit ? 32'(1 << m_ptr) : 32'd0);
        check_eq("slot", 32'(bus.slot), 32'(m_slot));
        check_eq("alarm_val", 32'(bus.alarm_val), 32'(model_val(m_slot)));
        check_eq("armed", 32'(bus.armed), 32'(av));
        check_eq("ring", 32'(bus.ring), 32'(m_ring));
        check_eq("ring_slot", 32'(bus.ring_slot), 32'(m_ring_slot));
        check_eq("finish", 32'(bus.finish), 32'(m_fin));
    endtask

    // One clock: drive inputs, advance model, sample DUT 1 time unit after the edge.
    task automatic cyc(input logic [6:0] p);
        bus.push_u = p[0]; bus.push_d = p[1]; bus.push_l = p[2]; bus.push_r = p[3];
        bus.push_c = p[4]; bus.tick = p[5]; bus.ack = p[6];
        bus.edit_en = en_r; bus.cur_time = cur_r;
        model_step(p, en_r, int'(cur_r));
        @(posedge clk);
        #1;
        compare_all();
        bus.push_u = 0; bus.push_d = 0; bus.push_l = 0; bus.push_r = 0;
        bus.push_c = 0; bus.tick = 0; bus.ack = 0;
    endtask

    // Asynchronous reset pulse placed mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        check_eq("rst_ring", 32'(bus.ring), 32'd0);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [6:0] p;
        en_r = 0; cur_r = 16'h0000;
        bus.edit_en = 0; bus.cur_time = 0;
        bus.push_u = 0; bus.push_d = 0; bus.push_l = 0; bus.push_r = 0;
        bus.push_c = 0; bus.tick = 0; bus.ack = 0;
        do_reset();

        // Edit digits: 3 up on min tens, right, down on min ones.
        en_r = 1; cyc(0);
        repeat (3) cyc(PU);
        cyc(PR); cyc(PD);
        check_eq("r031_val", 32'(bus.alarm_val), 32'h3900);
        check_eq("r031_sel", 32'(bus.sel), 32'b0100);

        // Sec tens digit wraps at 5.
        cyc(PR);
        for (int i = 1; i <= 6; i++) begin
            cyc(PU);
            check_eq("r032_up", 32'(bus.alarm_val[7:4]), 32'(i % 6));
        end
        cyc(PD);
        check_eq("r032_dn", 32'(bus.alarm_val[7:4]), 32'd5);
        cyc(PL);
        check_eq("sel_left", 32'(bus.sel), 32'b0100);

        // Arm slot0 at 00:05, ring and ack.
        en_r = 0; cyc(0);
        do_reset();
        en_r = 1; cyc(0);
        cyc(PR); cyc(PR); cyc(PR);
        check_eq("sel_r3", 32'(bus.sel), 32'b0001);
        cyc(PR);
        check_eq("sel_wrap_r", 32'(bus.sel), 32'b1000);
        cyc(PL);
        check_eq("sel_wrap_l", 32'(bus.sel), 32'b0001);
        repeat (5) cyc(PU);
        en_r = 0; cyc(0);
        check_eq("r033_fin", 32'(bus.finish), 32'd1);
        check_eq("r033_armed", 32'(bus.armed), 32'b0001);
        cyc(0);
        check_eq("r033_fin_low", 32'(bus.finish), 32'd0);
        cur_r = 16'h0005; cyc(PT);
        check_eq("r033_ring", 32'(bus.ring), 32'd1);
        check_eq("r033_rslot", 32'(bus.ring_slot), 32'd0);
        cyc(PA);
        check_eq("r033_ack", 32'(bus.ring), 32'd0);
        check_eq("r033_disarm", 32'(bus.armed), 32'b0000);

        // Re-arm and let it time out after RS ticks.
        en_r = 1; cyc(0); en_r = 0; cyc(0);
        cyc(PT);
        check_eq("r034_ring", 32'(bus.ring), 32'd1);
        cur_r = 16'h1234;
        cyc(PT); cyc(PT);
        check_eq("r034_still", 32'(bus.ring), 32'd1);
        cyc(PT);
        check_eq("r034_off", 32'(bus.ring), 32'd0);
        check_eq("r034_armed", 32'(bus.armed[0]), 32'd1);

        // Slots 1 and 2 at 01:00, lowest index wins; slot counter wraps.
        do_reset();
        for (int s = 1; s <= 2; s++) begin
            cyc(PC);
            en_r = 1; cyc(0); cyc(PR); cyc(PU); en_r = 0; cyc(0);
        end
        check_eq("r035_armed", 32'(bus.armed), 32'b0110);
        cur_r = 16'h0100; cyc(PT);
        check_eq("r035_rslot", 32'(bus.ring_slot), 32'd1);
        cyc(PC); cyc(PC);
        check_eq("r035_wrap", 32'(bus.slot), 32'd0);
        cyc(PA);

        // Reset while ringing and editing.
        en_r = 1; cyc(0); en_r = 0; cyc(0);
        cur_r = 16'h0000; cyc(PT);
        en_r = 1; cyc(0);
        check_eq("r036_pre", 32'({bus.ring, bus.sel}), 32'h18);
        #2;
        do_reset();
        en_r = 0; cyc(0);
        cyc(PT);
        check_eq("r036_noring", 32'(bus.ring), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            p = 0;
            if ($urandom_range(0, 3) == 0) p |= PU;
            if ($urandom_range(0, 3) == 0) p |= PD;
            if ($urandom_range(0, 3) == 0) p |= PL;
            if ($urandom_range(0, 3) == 0) p |= PR;
            if ($urandom_range(0, 3) == 0) p |= PC;
            if ($urandom_range(0, 2) == 0) p |= PT;
            if ($urandom_range(0, 5) == 0) p |= PA;
            if ($urandom_range(0, 9) == 0) en_r = ~en_r;
            if ($urandom_range(0, 1) == 0) cur_r = 16'(model_val($urandom_range(0, NS - 1)));
            else cur_r = 16'($urandom);
            cyc(p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
